mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single synchronous-read RAM port between the CPU (requester 0) and a loader/DMA engine (requester 1). It sequences every RAM access through a fixed three-state machine: grant, drive the RAM, then return read data with a one-cycle acknowledge. It sits between the controller/datapath memory interface and the RAM instance, and replaces the direct controller-to-RAM address/write wiring.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master RAM arbiter.
// States and owner encodings used by mem_arbiter and arb_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection for mem_arbiter (combinational).
// MEM_ARB_RR_EN selects round-robin; default is fixed m0 priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWN_NONE;
    unique case (1'b1)
      (req0 && !req1): winner = OWN_M0;
      (req1 && !req0): winner = OWN_M1;
      (req0 && req1):  winner = last_grant ? OWN_M0 : OWN_M1;
      default:         winner = OWN_NONE;
    endcase
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = OWN_NONE;
    unique case (1'b1)
      req0:            winner = OWN_M0;
      (!req0 && req1): winner = OWN_M1;
      default:         winner = OWN_NONE;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a synchronous-read RAM port.
// Arbitration policy set by MEM_ARB_RR_EN (see arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic              last_q, last_d;
  logic [1:0]        winner;

  // last_q only has a load in the round-robin build
  arb_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_q),
    .winner     (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (winner != OWN_NONE) begin
          state_d = ACCESS;
          owner_d = winner;
          if (winner == OWN_M1) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            wen_d   = m1_we;
            last_d  = 1'b1;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            wen_d   = m0_we;
            last_d  = 1'b0;
          end
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      last_q  <= last_d;
    end
  end

  logic in_resp;
  assign in_resp = (state_q == RESP);

  assign m0_ack   = in_resp && (owner_q == OWN_M0);
  assign m1_ack   = in_resp && (owner_q == OWN_M1);
  assign m0_rdata = m0_ack ? ram_rdata : '0;
  assign m1_rdata = m1_ack ? ram_rdata : '0;

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_w_en  = wen_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter.
// Transaction-level reference: memory array plus last-winner tracking.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [7:0]  m0_addr = '0;
  logic [15:0] m0_wdata = '0;
  logic        m0_ack;
  logic [15:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [7:0]  m1_addr = '0;
  logic [15:0] m1_wdata = '0;
  logic        m1_ack;
  logic [15:0] m1_rdata;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_w_en;
  logic [15:0] ram_rdata;
  logic [1:0]  owner;

  int checks = 0;
  int passes = 0;

  logic [15:0] ref_mem [256];
  int          ref_last = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_w_en(ram_w_en), .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack <= 1'b0;
    end else begin
      checks++;
      if (m0_ack && m1_ack)
        $display("FAIL mon_dual_ack m0_ack=%b m1_ack=%b need not both", m0_ack, m1_ack);
      else if (prev_ack && (m0_ack || m1_ack))
        $display("FAIL mon_ack_consec ack high two cycles, need single pulse");
      else if ((!m0_ack && m0_rdata !== 16'h0) || (!m1_ack && m1_rdata !== 16'h0))
        $display("FAIL mon_rdata_idle m0=%h m1=%h need 0", m0_rdata, m1_rdata);
      else
        passes++;
      prev_ack <= m0_ack || m1_ack;
    end
  end

  function automatic int exp_winner(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef MEM_ARB_RR_EN
    return (ref_last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic wait_ack(output int who, output logic [15:0] rd,
                          output int lat, output int wen_n,
                          output logic [7:0] wen_a);
    who = -1; rd = '0; lat = 0; wen_n = 0; wen_a = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ram_w_en) begin
        wen_n++;
        wen_a = ram_addr;
      end
      if (m0_ack || m1_ack) begin
        who = m0_ack ? (m1_ack ? 3 : 0) : 1;
        rd  = m0_ack ? m0_rdata : m1_rdata;
        break;
      end
    end
  endtask

  task automatic release_reqs();
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({owner, m0_ack, m1_ack, ram_w_en} !== 5'b0 ||
        m0_rdata !== 16'h0 || m1_rdata !== 16'h0 ||
        ram_addr !== 8'h0 || ram_wdata !== 16'h0)
      $display("FAIL reset_vals owner=%b ack=%b%b wen=%b addr=%h wd=%h need all 0",
               owner, m0_ack, m1_ack, ram_w_en, ram_addr, ram_wdata);
    else passes++;
    rst_n = 1'b1;
    ref_last = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_m0_read();
    int who, lat, wn;
    logic [15:0] rd;
    logic [7:0] wa;
    m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 16'hBEEF; m0_req = 1'b1;
    wait_ack(who, rd, lat, wn, wa);
    release_reqs();
    ref_mem[8'h10] = 16'hBEEF; ref_last = 0;
    m0_we = 1'b0; m0_addr = 8'h10; m0_req = 1'b1;
    wait_ack(who, rd, lat, wn, wa);
    checks++;
    if (who !== 0 || lat !== 2)
      $display("FAIL m0_read_ack who=%0d lat=%0d need who=0 lat=2", who, lat);
    else passes++;
    checks++;
    if (rd !== ref_mem[8'h10])
      $display("FAIL m0_read_data got %h need %h", rd, ref_mem[8'h10]);
    else passes++;
    release_reqs();
    checks++;
    if (owner !== 2'b00)
      $display("FAIL m0_read_owner got %b need 00", owner);
    else passes++;
  endtask

  task automatic test_m1_write_read();
    int who, lat, wn;
    logic [15:0] rd;
    logic [7:0] wa;
    m1_we = 1'b1; m1_addr = 8'h20; m1_wdata = 16'h1234; m1_req = 1'b1;
    wait_ack(who, rd, lat, wn, wa);
    checks++;
    if (who !== 1 || lat !== 2 || wn !== 1 || wa !== 8'h20)
      $display("FAIL m1_write who=%0d lat=%0d wen_cycles=%0d addr=%h need 1/2/1/20",
               who, lat, wn, wa);
    else passes++;
    release_reqs();
    ref_mem[8'h20] = 16'h1234; ref_last = 1;
    m1_we = 1'b0; m1_req = 1'b1;
    wait_ack(who, rd, lat, wn, wa);
    checks++;
    if (who !== 1 || rd !== ref_mem[8'h20] || wn !== 0)
      $display("FAIL m1_read who=%0d data=%h wen_cycles=%0d need 1/%h/0",
               who, rd, wn, ref_mem[8'h20]);
    else passes++;
    release_reqs();
  endtask

  task automatic test_contention();
    int who, lat, wn, ew;
    logic [15:0] rd;
    logic [7:0] wa, a0, a1;
    a0 = 8'h10; a1 = 8'h20;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = a0; m1_addr = a1;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ew = exp_winner(1'b1, 1'b1);
      wait_ack(who, rd, lat, wn, wa);
      checks++;
      if (who !== ew || lat !== ((i == 0) ? 2 : 3))
        $display("FAIL contend_%0d who=%0d lat=%0d need who=%0d lat=%0d",
                 i, who, lat, ew, (i == 0) ? 2 : 3);
      else passes++;
      checks++;
      if (rd !== ref_mem[(ew == 0) ? a0 : a1])
        $display("FAIL contend_data_%0d got %h need %h",
                 i, rd, ref_mem[(ew == 0) ? a0 : a1]);
      else passes++;
      ref_last = ew;
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      m0_addr = a0; m1_addr = a1;
    end
    release_reqs();
  endtask

  task automatic test_drop_req();
    int who, lat, wn, extra;
    logic [15:0] rd;
    logic [7:0] wa;
    m0_we = 1'b0; m0_addr = 8'h20; m0_req = 1'b1;
    @(posedge clk); #1;
    m0_req = 1'b0;
    wait_ack(who, rd, lat, wn, wa);
    checks++;
    if (who !== 0 || lat !== 1 || rd !== ref_mem[8'h20])
      $display("FAIL drop_req who=%0d lat=%0d data=%h need 0/1/%h",
               who, lat, rd, ref_mem[8'h20]);
    else passes++;
    ref_last = 0;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack || owner !== 2'b00) extra++;
    end
    checks++;
    if (extra !== 0)
      $display("FAIL drop_req_after bad_cycles=%0d need 0", extra);
    else passes++;
  endtask

  task automatic test_reset_mid_write();
    int who, lat, wn;
    logic [15:0] rd;
    logic [7:0] wa;
    m0_we = 1'b1; m0_addr = 8'h30; m0_wdata = 16'h5A5A; m0_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ram_w_en !== 1'b1 || ram_addr !== 8'h30)
      $display("FAIL rst_mid_access wen=%b addr=%h need 1/30", ram_w_en, ram_addr);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({owner, m0_ack, m1_ack, ram_w_en} !== 5'b0 ||
        ram_addr !== 8'h0 || ram_wdata !== 16'h0 || m0_rdata !== 16'h0)
      $display("FAIL rst_mid_vals owner=%b wen=%b addr=%h wd=%h need 0",
               owner, ram_w_en, ram_addr, ram_wdata);
    else passes++;
    m0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_last = 0;
    m0_we = 1'b0; m0_req = 1'b1;
    wait_ack(who, rd, lat, wn, wa);
    checks++;
    if (who !== 0 || rd !== ref_mem[8'h30])
      $display("FAIL rst_mid_readback who=%0d data=%h need 0/%h",
               who, rd, ref_mem[8'h30]);
    else passes++;
    release_reqs();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (owner !== 2'b00 || ram_w_en || m0_ack || m1_ack) bad++;
    end
    checks++;
    if (bad !== 0)
      $display("FAIL idle_quiet bad_cycles=%0d need 0", bad);
    else passes++;
  endtask

  task automatic test_random();
    int who, lat, wn, mode, ew;
    logic [15:0] rd;
    logic [7:0] wa, ea;
    logic ewe;
    logic [15:0] ed;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      m0_we = 1'($urandom); m0_addr = 8'($urandom);
      m0_wdata = 16'($urandom);
      m1_we = 1'($urandom); m1_addr = 8'($urandom);
      m1_wdata = 16'($urandom);
      m0_req = (mode != 1);
      m1_req = (mode != 0);
      ew  = exp_winner(m0_req, m1_req);
      ewe = (ew == 0) ? m0_we : m1_we;
      ea  = (ew == 0) ? m0_addr : m1_addr;
      ed  = (ew == 0) ? m0_wdata : m1_wdata;
      wait_ack(who, rd, lat, wn, wa);
      checks++;
      if (who !== ew || lat !== 2)
        $display("FAIL rand_%0d_grant who=%0d lat=%0d need %0d/2", i, who, lat, ew);
      else passes++;
      checks++;
      if (ewe && (wn !== 1 || wa !== ea))
        $display("FAIL rand_%0d_wr wen_cycles=%0d addr=%h need 1/%h", i, wn, wa, ea);
      else if (!ewe && (wn !== 0 || rd !== ref_mem[ea]))
        $display("FAIL rand_%0d_rd wen_cycles=%0d data=%h need 0/%h",
                 i, wn, rd, ref_mem[ea]);
      else passes++;
      if (ewe) ref_mem[ea] = ed;
      ref_last = ew;
      release_reqs();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    test_reset();
    test_m0_read();
    test_m1_write_read();
    test_contention();
    test_drop_req();
    test_reset_mid_write();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
